// File: rtl/fuzz_round_sequencer.sv
// Purpose: sequences fuzzing rounds (load -> hold reset -> run -> collect) and kicks the DUT via msip on stall or watchdog.
// Latency: all outputs registered; each state transition is visible one cycle after the qualifying input is sampled.
// Backpressure: waits indefinitely on load_ack / collect_ack. Optional FUZZ_ROUND_STATS_EN adds pass/timeout/irq counters.
module fuzz_round_sequencer #(
  parameter int unsigned COV_W           = 30,
  parameter int unsigned MAX_WAIT_CYCLE  = 1000,
  parameter int unsigned STALL_SHIFT     = 19,
  parameter int unsigned WATCHDOG_CYCLES = 50000,
  parameter int unsigned ROUND_CYCLES    = 200000,
  parameter int unsigned RST_HOLD        = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [COV_W-1:0] cov,
  input  logic [63:0]      tohost,
  output logic             load_req,
  input  logic             load_ack,
  output logic             collect_req,
  input  logic             collect_ack,
  input  logic             collect_cont,
  output logic             dut_reset,
  output logic             interrupt,
  output logic             round_done,
  output logic [1:0]       round_status,
  output logic [31:0]      round_count,
  output logic             busy,
  output logic [31:0]      pass_cnt,
  output logic [31:0]      timeout_cnt,
  output logic [31:0]      irq_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HOLD    = 3'd2,
    S_RUN     = 3'd3,
    S_COLLECT = 3'd4,
    S_STOP    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [63:0] run_cnt_q, run_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;
  logic [63:0] wd_cnt_q, wd_cnt_d;
  logic [COV_W-1:0] prev_cov_q, prev_cov_d;
  logic        load_req_q, load_req_d;
  logic        collect_req_q, collect_req_d;
  logic        dut_reset_q, dut_reset_d;
  logic        interrupt_q, interrupt_d;
  logic        round_done_q, round_done_d;
  logic [1:0]  round_status_q, round_status_d;
  logic [31:0] round_count_q, round_count_d;
  logic        busy_q, busy_d;

  logic        end_pass, end_tout;
  logic [63:0] stall_thr;

  // Only the pass bit of tohost matters to the sequencer.
  logic unused_tohost;
  assign unused_tohost = ^tohost[63:1];

  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (v == {64{1'b1}}) ? v : v + 64'd1;
  endfunction

  // Next-state and registered-output computation; outputs are derived from the next state so they align with it.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    run_cnt_d      = run_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    wd_cnt_d       = wd_cnt_q;
    prev_cov_d     = cov;
    round_done_d   = 1'b0;
    round_status_d = round_status_q;
    round_count_d  = round_count_q;

    end_pass  = (state_q == S_RUN) && tohost[0];
    end_tout  = (state_q == S_RUN) && (run_cnt_q > 64'(ROUND_CYCLES));
    // Threshold scales with coverage magnitude; 32x31-bit product never overflows 64 bits.
    stall_thr = 64'(MAX_WAIT_CYCLE) * ((64'(cov) >> STALL_SHIFT) + 64'd1);

    case (state_q)
      S_IDLE, S_STOP: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (load_ack) begin
          state_d    = S_HOLD;
          hold_cnt_d = 32'd0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q >= 32'(RST_HOLD - 1)) begin
          state_d     = S_RUN;
          run_cnt_d   = 64'd0;
          stall_cnt_d = 64'd0;
          wd_cnt_d    = 64'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (end_pass || end_tout) begin
          // Pass takes priority when both end conditions coincide.
          state_d        = S_COLLECT;
          round_done_d   = 1'b1;
          round_status_d = end_pass ? 2'd1 : 2'd2;
          round_count_d  = round_count_q + 32'd1;
        end else begin
          run_cnt_d   = sat_inc(run_cnt_q);
          wd_cnt_d    = sat_inc(wd_cnt_q);
          stall_cnt_d = (cov != prev_cov_q) ? 64'd0 : sat_inc(stall_cnt_q);
        end
      end
      S_COLLECT: begin
        if (collect_ack) state_d = collect_cont ? S_LOAD : S_STOP;
      end
      default: state_d = S_IDLE;
    endcase

    load_req_d    = (state_d == S_LOAD);
    collect_req_d = (state_d == S_COLLECT);
    dut_reset_d   = (state_d != S_RUN);
    busy_d        = (state_d != S_IDLE) && (state_d != S_STOP);
    interrupt_d   = (state_d == S_RUN) &&
                    ((stall_cnt_d >= stall_thr) || (wd_cnt_d >= 64'(WATCHDOG_CYCLES)));
  end

  // Sequencer state and registered outputs; async reset aborts any round in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      hold_cnt_q     <= 32'd0;
      run_cnt_q      <= 64'd0;
      stall_cnt_q    <= 64'd0;
      wd_cnt_q       <= 64'd0;
      prev_cov_q     <= '0;
      load_req_q     <= 1'b0;
      collect_req_q  <= 1'b0;
      dut_reset_q    <= 1'b1;
      interrupt_q    <= 1'b0;
      round_done_q   <= 1'b0;
      round_status_q <= 2'd0;
      round_count_q  <= 32'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      run_cnt_q      <= run_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      prev_cov_q     <= prev_cov_d;
      load_req_q     <= load_req_d;
      collect_req_q  <= collect_req_d;
      dut_reset_q    <= dut_reset_d;
      interrupt_q    <= interrupt_d;
      round_done_q   <= round_done_d;
      round_status_q <= round_status_d;
      round_count_q  <= round_count_d;
      busy_q         <= busy_d;
    end
  end

  assign load_req     = load_req_q;
  assign collect_req  = collect_req_q;
  assign dut_reset    = dut_reset_q;
  assign interrupt    = interrupt_q;
  assign round_done   = round_done_q;
  assign round_status = round_status_q;
  assign round_count  = round_count_q;
  assign busy         = busy_q;

`ifdef FUZZ_ROUND_STATS_EN
  logic [31:0] pass_cnt_q, pass_cnt_d;
  logic [31:0] timeout_cnt_q, timeout_cnt_d;
  logic [31:0] irq_cnt_q, irq_cnt_d;

  // Round outcome counters and interrupt rising-edge counter, all wrapping.
  always_comb begin
    pass_cnt_d    = pass_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    irq_cnt_d     = irq_cnt_q;
    if (end_pass)                      pass_cnt_d    = pass_cnt_q + 32'd1;
    else if (end_tout)                 timeout_cnt_d = timeout_cnt_q + 32'd1;
    if (interrupt_d && !interrupt_q)   irq_cnt_d     = irq_cnt_q + 32'd1;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_cnt_q    <= 32'd0;
      timeout_cnt_q <= 32'd0;
      irq_cnt_q     <= 32'd0;
    end else begin
      pass_cnt_q    <= pass_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      irq_cnt_q     <= irq_cnt_d;
    end
  end

  assign pass_cnt    = pass_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
  assign irq_cnt     = irq_cnt_q;
`else
  assign pass_cnt    = 32'd0;
  assign timeout_cnt = 32'd0;
  assign irq_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_fuzz_round_sequencer.sv
// Purpose: directed bench for fuzz_round_sequencer covering round flow, stall/watchdog interrupt, end priority, reset abort.
// Latency: outputs sampled 1 time unit after each rising clock edge, inputs driven at the same point.
// Backpressure: bench drives load_ack / collect_ack directly on fixed cycles.
module tb_fuzz_round_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [29:0] cov;
  logic [63:0] tohost;
  logic        load_req, load_ack;
  logic        collect_req, collect_ack, collect_cont;
  logic        dut_reset, interrupt, round_done, busy;
  logic [1:0]  round_status;
  logic [31:0] round_count, pass_cnt, timeout_cnt, irq_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FUZZ_ROUND_STATS_EN
  localparam logic [31:0] EXP_PASS = 32'd3;
  localparam logic [31:0] EXP_TOUT = 32'd1;
  localparam logic [31:0] EXP_IRQ  = 32'd3;
`else
  localparam logic [31:0] EXP_PASS = 32'd0;
  localparam logic [31:0] EXP_TOUT = 32'd0;
  localparam logic [31:0] EXP_IRQ  = 32'd0;
`endif

  fuzz_round_sequencer #(
    .COV_W(30), .MAX_WAIT_CYCLE(10), .STALL_SHIFT(4),
    .WATCHDOG_CYCLES(50), .ROUND_CYCLES(100), .RST_HOLD(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cov(cov), .tohost(tohost),
    .load_req(load_req), .load_ack(load_ack),
    .collect_req(collect_req), .collect_ack(collect_ack), .collect_cont(collect_cont),
    .dut_reset(dut_reset), .interrupt(interrupt), .round_done(round_done),
    .round_status(round_status), .round_count(round_count), .busy(busy),
    .pass_cnt(pass_cnt), .timeout_cnt(timeout_cnt), .irq_cnt(irq_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ack a pending load, sit through the reset hold, land on RUN cycle 0.
  task automatic load_and_hold(input string tag);
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    chk_b({tag, " load_req drop"}, load_req, 1'b0);
    repeat (3) tick();
    chk_b({tag, " hold last"}, dut_reset, 1'b1);
    tick();
    chk_b({tag, " run entry"}, dut_reset, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_b({tag, " dut_reset"}, dut_reset, 1'b1);
    chk_b({tag, " load_req"}, load_req, 1'b0);
    chk_b({tag, " collect_req"}, collect_req, 1'b0);
    chk_b({tag, " interrupt"}, interrupt, 1'b0);
    chk_b({tag, " round_done"}, round_done, 1'b0);
    chk_b({tag, " busy"}, busy, 1'b0);
    chk_w({tag, " status"}, 32'(round_status), 32'd0);
    chk_w({tag, " count"}, round_count, 32'd0);
    chk_w({tag, " pass_cnt"}, pass_cnt, 32'd0);
    chk_w({tag, " timeout_cnt"}, timeout_cnt, 32'd0);
    chk_w({tag, " irq_cnt"}, irq_cnt, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; cov = '0; tohost = '0;
    load_ack = 1'b0; collect_ack = 1'b0; collect_cont = 1'b0;
    repeat (2) tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();
    chk_b("idle busy", busy, 1'b0);
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    chk_b("idle ack ignored", load_req, 1'b0);
    chk_b("idle ack busy", busy, 1'b0);

    // Round 1: pass at RUN cycle 20, coverage moving every cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_b("t1 load_req", load_req, 1'b1);
    chk_b("t1 busy", busy, 1'b1);
    chk_b("t1 dut_reset load", dut_reset, 1'b1);
    tick();
    tick();
    chk_b("t1 load_req held", load_req, 1'b1);
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    chk_b("t1 load_req drop", load_req, 1'b0);
    repeat (3) begin
      tick();
      chk_b("t1 hold", dut_reset, 1'b1);
    end
    tick();
    chk_b("t1 run entry", dut_reset, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cov = 30'(k + 1);
      chk_b("t1 no irq", interrupt, 1'b0);
      tick();
    end
    tohost = 64'd1;
    tick();
    tohost = 64'd0;
    chk_b("t1 round_done", round_done, 1'b1);
    chk_w("t1 status", 32'(round_status), 32'd1);
    chk_w("t1 count", round_count, 32'd1);
    chk_b("t1 dut_reset end", dut_reset, 1'b1);
    chk_b("t1 collect_req", collect_req, 1'b1);
    tick();
    chk_b("t1 round_done pulse", round_done, 1'b0);
    chk_w("t1 status held", 32'(round_status), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_b("t1 start ignored collect", collect_req, 1'b1);
    chk_b("t1 start ignored load", load_req, 1'b0);
    collect_ack = 1'b1; collect_cont = 1'b1;
    tick();
    collect_ack = 1'b0;
    chk_b("t5 cont load_req", load_req, 1'b1);
    chk_b("t5 cont collect_req", collect_req, 1'b0);

    // Round 2: constant coverage -> stall irq at 10, timeout after run count 101.
    cov = 30'd5;
    load_and_hold("t2");
    for (int k = 0; k <= 100; k++) begin
      chk_b("t2 irq", interrupt, k >= 10);
      tick();
    end
    chk_b("t2 irq before end", interrupt, 1'b1);
    chk_b("t2 no early done", round_done, 1'b0);
    tick();
    chk_b("t2 round_done", round_done, 1'b1);
    chk_w("t2 status", 32'(round_status), 32'd2);
    chk_w("t2 count", round_count, 32'd2);
    chk_b("t2 irq cleared", interrupt, 1'b0);
    chk_b("t2 dut_reset", dut_reset, 1'b1);
    collect_ack = 1'b1; collect_cont = 1'b1;
    tick();
    collect_ack = 1'b0;

    // Round 3: cov 0x20 scales stall threshold to 30; end by pass at cycle 40.
    cov = 30'h20;
    load_and_hold("t3a");
    for (int k = 0; k < 40; k++) begin
      chk_b("t3a irq", interrupt, k >= 30);
      tick();
    end
    tohost = 64'd1;
    tick();
    tohost = 64'd0;
    chk_w("t3a status", 32'(round_status), 32'd1);
    chk_w("t3a count", round_count, 32'd3);
    chk_b("t3a irq cleared", interrupt, 1'b0);
    collect_ack = 1'b1; collect_cont = 1'b1;
    tick();
    collect_ack = 1'b0;

    // Round 4: cov steps every 5 cycles -> watchdog irq at 50; pass and timeout together.
    load_and_hold("t3b");
    for (int k = 0; k <= 100; k++) begin
      cov = 30'(k / 5);
      chk_b("t3b irq", interrupt, k >= 50);
      tick();
    end
    tohost = 64'd1;
    tick();
    tohost = 64'd0;
    chk_b("t4 round_done", round_done, 1'b1);
    chk_w("t4 pass wins", 32'(round_status), 32'd1);
    chk_w("t4 count", round_count, 32'd4);
    chk_w("stats pass", pass_cnt, EXP_PASS);
    chk_w("stats timeout", timeout_cnt, EXP_TOUT);
    chk_w("stats irq", irq_cnt, EXP_IRQ);

    // Collect with cont=0 -> STOP, then restart.
    collect_ack = 1'b1; collect_cont = 1'b0;
    tick();
    collect_ack = 1'b0;
    chk_b("t5 stop busy", busy, 1'b0);
    chk_b("t5 stop collect_req", collect_req, 1'b0);
    chk_b("t5 stop dut_reset", dut_reset, 1'b1);
    chk_w("t5 stop count", round_count, 32'd4);
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    chk_b("t5 stop ack ignored", load_req, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_b("t5 restart load_req", load_req, 1'b1);
    chk_b("t5 restart busy", busy, 1'b1);

    // Round 6: abort with async reset mid-RUN while interrupt is asserted.
    cov = 30'd3;
    load_and_hold("t6");
    repeat (12) tick();
    chk_b("t6 irq before abort", interrupt, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t6 abort");
    repeat (3) tick();
    chk_b("t6 no round_done", round_done, 1'b0);
    reset = 1'b1;
    tick();
    chk_b("t6 idle after reset", busy, 1'b0);
    chk_w("t6 count cleared", round_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
